// File: rtl/watch_pkg.sv
// Shared constants for the watch display: segment patterns, digit slot indices
// and field range limits.
package watch_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    localparam logic [2:0] DIG_SEC1   = 3'd0;
    localparam logic [2:0] DIG_SEC10  = 3'd1;
    localparam logic [2:0] DIG_MIN1   = 3'd2;
    localparam logic [2:0] DIG_MIN10  = 3'd3;
    localparam logic [2:0] DIG_HOUR1  = 3'd4;
    localparam logic [2:0] DIG_HOUR10 = 3'd5;

    localparam int MAX_MIN_SEC = 59;
    localparam int MAX_HOUR    = 23;

    // Active-high {g,f,e,d,c,b,a} pattern for one BCD digit; non-decimal codes show a dash.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/watch_bin2bcd.sv
// Combinational 6-bit binary to two-digit BCD, with a range flag against MAX.
module watch_bin2bcd #(
    parameter int MAX = 59
) (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid
);

    // Low nibble of tens*10; ones is then a 4-bit wrap-around subtraction.
    logic [3:0] base_lo;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        tens    = 4'd0;
        base_lo = 4'd0;
        if (bin >= 6'd60) begin
            tens    = 4'd6;
            base_lo = 4'hC;
        end else if (bin >= 6'd50) begin
            tens    = 4'd5;
            base_lo = 4'h2;
        end else if (bin >= 6'd40) begin
            tens    = 4'd4;
            base_lo = 4'h8;
        end else if (bin >= 6'd30) begin
            tens    = 4'd3;
            base_lo = 4'hE;
        end else if (bin >= 6'd20) begin
            tens    = 4'd2;
            base_lo = 4'h4;
        end else if (bin >= 6'd10) begin
            tens    = 4'd1;
            base_lo = 4'hA;
        end
        ones  = bin[3:0] - base_lo;
        valid = (bin <= 6'(MAX));
    end

endmodule

// File: rtl/watch_display.sv
// Six-digit multiplexed 7-segment driver for hh:mm:ss with a frame-coherent
// time snapshot and a 1 Hz blinking colon.
module watch_display
    import watch_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_1hz,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] digit_sel
);

    localparam int         CNT_W   = $clog2(SCAN_DIV);
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [5:0] DIG_POL = {6{DIG_ACTIVE_LOW}};

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [4:0]       snap_h;
    logic [5:0]       snap_m;
    logic [5:0]       snap_s;
    logic             colon_ph;

    logic             terminal;
    logic             frame_end;

    assign terminal  = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = terminal && (idx == DIG_HOUR10);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt      <= '0;
            idx      <= DIG_SEC1;
            snap_h   <= '0;
            snap_m   <= '0;
            snap_s   <= '0;
            colon_ph <= 1'b0;
        end else begin
            cnt <= terminal ? '0 : cnt + CNT_W'(1);
            if (terminal) begin
                idx <= (idx == DIG_HOUR10) ? DIG_SEC1 : idx + 3'd1;
            end
            // Load only at the frame boundary so one scan never mixes two times.
            if (frame_end) begin
                snap_h <= hour;
                snap_m <= minute;
                snap_s <= second;
            end
            if (en_1hz) begin
                colon_ph <= ~colon_ph;
            end
        end
    end

    logic [3:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
    logic       h_valid, m_valid, s_valid;

    watch_bin2bcd #(.MAX(MAX_HOUR)) u_bcd_hour (
        .bin   ({1'b0, snap_h}),
        .tens  (h_tens),
        .ones  (h_ones),
        .valid (h_valid)
    );

    watch_bin2bcd #(.MAX(MAX_MIN_SEC)) u_bcd_min (
        .bin   (snap_m),
        .tens  (m_tens),
        .ones  (m_ones),
        .valid (m_valid)
    );

    watch_bin2bcd #(.MAX(MAX_MIN_SEC)) u_bcd_sec (
        .bin   (snap_s),
        .tens  (s_tens),
        .ones  (s_ones),
        .valid (s_valid)
    );

    logic [3:0] digit_val;
    logic       field_ok;
    logic [6:0] seg_hi;
    logic [5:0] dig_hi;
    logic       dp_hi;

    always_comb begin
        digit_val = 4'd0;
        field_ok  = 1'b0;
        case (idx)
            DIG_SEC1:   begin digit_val = s_ones; field_ok = s_valid; end
            DIG_SEC10:  begin digit_val = s_tens; field_ok = s_valid; end
            DIG_MIN1:   begin digit_val = m_ones; field_ok = m_valid; end
            DIG_MIN10:  begin digit_val = m_tens; field_ok = m_valid; end
            DIG_HOUR1:  begin digit_val = h_ones; field_ok = h_valid; end
            DIG_HOUR10: begin digit_val = h_tens; field_ok = h_valid; end
            default:    begin digit_val = 4'd0;   field_ok = 1'b0;    end
        endcase
        seg_hi = field_ok ? seg_encode(digit_val) : SEG_DASH;
        dig_hi = 6'b000001 << idx;
        dp_hi  = colon_ph && ((idx == DIG_MIN1) || (idx == DIG_HOUR1));
    end

    // Polarity is folded in at the register so the pins never glitch through an inverter.
    always_ff @(posedge clk) begin
        if (rst || blank) begin
            seg       <= SEG_POL;
            dp        <= SEG_ACTIVE_LOW;
            digit_sel <= DIG_POL;
        end else begin
            seg       <= seg_hi ^ SEG_POL;
            dp        <= dp_hi ^ SEG_ACTIVE_LOW;
            digit_sel <= dig_hi ^ DIG_POL;
        end
    end

endmodule

// File: tb/tb_watch_display.sv
// Scoreboard bench for watch_display: expected slots are queued as stimulus is
// driven and compared by a monitor one step after every clock edge.
module tb_watch_display;

    localparam int SD    = 4;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_1hz;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       blank;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] digit_sel;

    always #5 clk = ~clk;

    watch_display #(
        .SCAN_DIV       (SD),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_1hz    (en_1hz),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .blank     (blank),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel)
    );

    typedef struct {
        logic [5:0] dig;
        logic [6:0] seg;
        logic       dp;
        string      tag;
    } exp_t;

    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Active-high pattern the spec requires for slot k of time h:m:s.
    function automatic logic [6:0] exp_seg(input int h, input int m, input int s, input int k);
        int v;
        bit ok;
        v  = 0;
        ok = 1'b1;
        case (k)
            0: begin v = s % 10; ok = (s <= 59); end
            1: begin v = s / 10; ok = (s <= 59); end
            2: begin v = m % 10; ok = (m <= 59); end
            3: begin v = m / 10; ok = (m <= 59); end
            4: begin v = h % 10; ok = (h <= 23); end
            default: begin v = h / 10; ok = (h <= 23); end
        endcase
        return ok ? SEG_TAB[v] : 7'h40;
    endfunction

    task automatic push_frame(input int h, input int m, input int s, input bit colon,
                              input int blank_from, input int blank_to, input int slots,
                              input string tag);
        for (int i = 0; i < slots; i++) begin
            int   k;
            exp_t e;
            k = i / SD;
            if (i >= blank_from && i < blank_to) begin
                e.dig = 6'h3F;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end else begin
                e.dig = ~(6'b000001 << k);
                e.seg = ~exp_seg(h, m, s, k);
                e.dp  = ~(colon && (k == 2 || k == 4));
            end
            e.tag = $sformatf("%s_slot%0d", tag, i);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.dig = 6'h3F;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            e.tag = $sformatf("%s_%0d", tag, i);
            exp_q.push_back(e);
        end
    endtask

    // Step n edges; land after the monitor has sampled that edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (digit_sel !== mon_e.dig) begin
                bad++;
                $display("FAIL %s digit_sel got %h want %h", mon_e.tag, digit_sel, mon_e.dig);
            end
            total++;
            if (seg !== mon_e.seg) begin
                bad++;
                $display("FAIL %s seg got %h want %h", mon_e.tag, seg, mon_e.seg);
            end
            total++;
            if (dp !== mon_e.dp) begin
                bad++;
                $display("FAIL %s dp got %b want %b", mon_e.tag, dp, mon_e.dp);
            end
        end
    end

    task automatic test_reset();
        push_idle(3, "reset_hold");
        cycles(3);
        total++;
        if (digit_sel !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
            bad++;
            $display("FAIL reset_defaults got dig=%h seg=%h dp=%b want dig=3f seg=7f dp=1",
                     digit_sel, seg, dp);
        end
        rst = 1'b0;
        push_frame(0, 0, 0, 1'b0, 0, 0, FRAME, "zero_frame");
        cycles(1);
        total++;
        if (digit_sel !== 6'h3E || seg !== 7'h40) begin
            bad++;
            $display("FAIL first_edge got dig=%h seg=%h want dig=3e seg=40", digit_sel, seg);
        end
        cycles(FRAME - 1);
    endtask

    task automatic test_display();
        push_frame(23, 59, 58, 1'b0, 0, 0, FRAME, "disp_235958");
        cycles(FRAME);
    endtask

    task automatic test_snapshot();
        push_frame(23, 59, 58, 1'b0, 0, 0, FRAME, "snap_old");
        cycles(10);
        second = 6'd59;
        cycles(FRAME - 10);
        push_frame(23, 59, 59, 1'b0, 0, 0, FRAME, "snap_new");
        cycles(FRAME);
    endtask

    task automatic test_out_of_range();
        minute = 6'd60;
        push_frame(23, 59, 59, 1'b0, 0, 0, FRAME, "oor_before");
        cycles(FRAME);
        push_frame(23, 60, 59, 1'b0, 0, 0, FRAME, "oor_min60");
        cycles(FRAME);
    endtask

    task automatic test_colon();
        hour   = 5'd12;
        minute = 6'd34;
        second = 6'd56;
        // First pulse lands on the snapshot edge of this frame.
        push_frame(23, 60, 59, 1'b0, 0, 0, FRAME, "colon_off");
        cycles(FRAME - 1);
        en_1hz = 1'b1;
        cycles(1);
        en_1hz = 1'b0;
        push_frame(12, 34, 56, 1'b1, 0, 0, FRAME, "colon_on");
        cycles(FRAME - 1);
        en_1hz = 1'b1;
        cycles(1);
        en_1hz = 1'b0;
        push_frame(12, 34, 56, 1'b0, 0, 0, FRAME, "colon_off2");
        cycles(FRAME);
    endtask

    task automatic test_blank_reset();
        push_frame(12, 34, 56, 1'b0, 3 * SD, 5 * SD, FRAME, "blank");
        cycles(3 * SD);
        blank = 1'b1;
        cycles(1);
        total++;
        if (digit_sel !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
            bad++;
            $display("FAIL blank_idx3 got dig=%h seg=%h dp=%b want dig=3f seg=7f dp=1",
                     digit_sel, seg, dp);
        end
        cycles(2 * SD - 1);
        blank = 1'b0;
        cycles(SD);

        push_frame(12, 34, 56, 1'b0, 0, 0, 4 * SD, "pre_reset");
        cycles(4 * SD);
        rst = 1'b1;
        push_idle(1, "mid_reset");
        cycles(1);
        total++;
        if (digit_sel !== 6'h3F) begin
            bad++;
            $display("FAIL mid_reset_dig got %h want 3f", digit_sel);
        end
        rst = 1'b0;
        push_frame(0, 0, 0, 1'b0, 0, 0, FRAME, "post_reset_zero");
        cycles(FRAME);
        push_frame(12, 34, 56, 1'b0, 0, 0, FRAME, "post_reset_time");
        cycles(FRAME);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired with %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        en_1hz = 1'b0;
        blank  = 1'b0;
        hour   = 5'd23;
        minute = 6'd59;
        second = 6'd58;

        test_reset();
        test_display();
        test_snapshot();
        test_out_of_range();
        test_colon();
        test_blank_reset();

        cycles(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/watch_display.md
# watch_display

Downstream consumer of the watch time counter: takes binary hour/minute/second and drives a 6-digit multiplexed 7-segment display. It snapshots the time once per scan frame so a display frame never mixes old and new values, converts each field to BCD, and scans the digits at a fixed refresh rate. The colon blinks from the shared 1 Hz enable.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot (1 kHz digit rate at 50 MHz); must be ≥ 2.
- `SEG_ACTIVE_LOW`, default 1: 1 inverts `seg` and `dp` at the output.
- `DIG_ACTIVE_LOW`, default 1: 1 inverts `digit_sel` at the output.
- `clk  in  1`: single clock for the whole block.
- `rst  in  1`: reset, **synchronous, active-high**.
- `en_1hz  in  1`: one-cycle pulse, once per second.
- `hour  in  5`: binary 0–23.
- `minute  in  6`: binary 0–59.
- `second  in  6`: binary 0–59.
- `blank  in  1`: 1 forces the display dark.
- `seg  out  7`: segments `{g,f,e,d,c,b,a}`.
- `dp  out  1`: decimal point, used as the colon.
- `digit_sel  out  6`: one-hot digit enable. Bit 0 is second ones; bit 5 is hour tens.

## Operation
- **Scan counter** `cnt` counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and digit index `idx` advances 0→1→…→5→0.
- **Digit map:**
  - idx0 = sec ones, idx1 = sec tens
  - idx2 = min ones, idx3 = min tens
  - idx4 = hour ones, idx5 = hour tens
- **Frame snapshot:** when `cnt` is at terminal and `idx==5`, the registers `snap_h/m/s` load `hour/minute/second` from that same cycle.
- **BCD conversion:** each snapshot field goes to tens/ones. Hour tens is always shown (24 h format, "00"–"23").
- **Out of range:** minute or second >59, or hour >23, shows dash (g only) on both digits of that field. Other fields are unaffected.
- **Segment encoding** (active-high, before polarity):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - dash=0x40
- **Colon:** `colon_ph` toggles on every `en_1hz` pulse. `dp` is lit only when `idx` ∈ {2,4} and `colon_ph==1`.
- **Blank:** `blank=1` drives all digits and segments inactive. `cnt`, `idx`, snapshot and `colon_ph` keep running.
- **Output registers:** `seg`, `dp` and `digit_sel` are registered, with polarity applied at the register output.

## Timing
- **Reset (`rst=1` at a clk edge):**
  - cnt=0, idx=0, snapshot=0, colon_ph=0
  - `digit_sel`, `seg`, `dp` all inactive (all-ones when active-low)
- **After reset release:**
  - First active output is on the 1st edge after `rst` falls: digit 0 shows "0" (0x3F).
  - Snapshot stays 0 until the first frame wrap, 6·SCAN_DIV cycles after release.
- **Output latency:** outputs reflect the new `idx` and `colon_ph` 1 cycle after the change. `blank` acts with 1-cycle latency.
- **Input-to-display latency:** a time change is visible within ≤ 6·SCAN_DIV + 1 cycles. Inputs are sampled only on the snapshot cycle.
- **One-hot rule:** `digit_sel` never has more than one bit active. No glitch states at idx wrap.
- **Simultaneous events:**
  - `en_1hz` on the snapshot cycle: both take effect in that cycle.
  - `rst` together with anything: reset wins.
- **Reset mid-frame:** the partial frame is discarded; the next reset-release behaviour is the same as from power-up.

## Structure
- **Package `watch_pkg`:**
  - `SEG_*` constants for digits 0–9 and dash.
  - Digit-index localparams `DIG_SEC1..DIG_HOUR10`.
  - Out-of-range limits 59/23.
- **Sub-module `watch_bin2bcd`:**
  - Combinational, 6-bit binary in → `tens[3:0]`, `ones[3:0]`, `valid` (input ≤ a MAX parameter).
  - Instantiated three times (hour with MAX=23, others 59).
- Scan counter, snapshot, colon phase and output registers stay in `watch_display`.

## Test plan
- **Reset:** `rst`=1 for 3 cycles → `digit_sel`=6'h3F, `seg`=7'h7F, `dp`=1 (active-low defaults). First edge after release → `digit_sel`=6'h3E, `seg`=~0x3F.
- **Display 23:59:58** (SCAN_DIV=4), inputs held → after first wrap, scanning idx0..5 gives active-high `seg` 0x7F, 0x6D, 0x6F, 0x6D, 0x4F, 0x5B.
- **Snapshot integrity:** change `second` 58→59 mid-frame → the current frame still shows 8. The next frame shows 9 on idx0 exactly at the first wrap after the change.
- **Out of range:** `minute`=60 → idx2 and idx3 show dash 0x40; hour and second digits are correct.
- **Colon:** pulse `en_1hz` once → `dp` active only during idx2/idx4 slots. Second pulse → `dp` never active.
- **Blank and reset mid-frame:**
  - `blank`=1 at idx3 → all outputs inactive next cycle.
  - Deassert at idx5 → scanning resumes in phase with no lost count.
  - `rst` at idx4 → `idx` 0 and outputs inactive next cycle.
